// File: rtl/pipe_div.sv
// Pipelined restoring divider: one op per cycle, fixed STAGES latency.
// Optional PIPE_DIV_SIGNED_EN selects two's complement operands.
module pipe_div #(
  parameter int BIT_WIDTH = 32,
  parameter int STAGES    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [BIT_WIDTH-1:0] dividend_i,
  input  logic [BIT_WIDTH-1:0] divisor_i,
  input  logic                 start_i,
  output logic [BIT_WIDTH-1:0] quotient_o,
  output logic [BIT_WIDTH-1:0] remainder_o,
  output logic                 div_zero_o,
  output logic                 done_o
);

  localparam int BPS = BIT_WIDTH / STAGES;

  if (BIT_WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipe_div: BIT_WIDTH must be a multiple of STAGES");
  end

  typedef struct packed {
    logic                 vld;
    logic                 dz;
`ifdef PIPE_DIV_SIGNED_EN
    logic                 qneg;
    logic                 rneg;
`endif
    logic [BIT_WIDTH:0]   rem;
    logic [BIT_WIDTH-1:0] dq;
    logic [BIT_WIDTH-1:0] dvs;
  } stage_t;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] q;
    logic [BIT_WIDTH-1:0] r;
  } res_t;

  // BPS restoring iterations; dq shifts dividend out and quotient in
  function automatic stage_t step(input stage_t s);
    stage_t             n;
    logic [BIT_WIDTH:0] t;
    n = s;
    for (int i = 0; i < BPS; i++) begin
      t    = {n.rem[BIT_WIDTH-1:0], n.dq[BIT_WIDTH-1]};
      n.dq = {n.dq[BIT_WIDTH-2:0], 1'b0};
      if (t >= {1'b0, n.dvs}) begin
        n.rem   = t - {1'b0, n.dvs};
        n.dq[0] = 1'b1;
      end else begin
        n.rem = t;
      end
    end
    return n;
  endfunction

  // Final result with divide-by-zero and sign correction applied
  function automatic res_t fixup(input stage_t s);
    res_t o;
    o.q = s.dq;
    o.r = s.rem[BIT_WIDTH-1:0];
`ifdef PIPE_DIV_SIGNED_EN
    if (s.qneg) o.q = -s.dq;
    if (s.rneg) o.r = -s.rem[BIT_WIDTH-1:0];
`endif
    if (s.dz) o.q = '1;
    return o;
  endfunction

  stage_t st_q [STAGES];
  stage_t st_d [STAGES];
  res_t   res;

  logic [BIT_WIDTH-1:0] quot_q, quot_d;
  logic [BIT_WIDTH-1:0] rem_q,  rem_d;
  logic                 dz_q,   dz_d;
  logic                 done_q, done_d;

  // Issue capture into stage 0, then one iteration group per stage
  always_comb begin
    st_d[0]     = '0;
    st_d[0].vld = start_i;
    st_d[0].dz  = (divisor_i == '0);
`ifdef PIPE_DIV_SIGNED_EN
    st_d[0].qneg = dividend_i[BIT_WIDTH-1] ^ divisor_i[BIT_WIDTH-1];
    st_d[0].rneg = dividend_i[BIT_WIDTH-1];
    st_d[0].dq   = dividend_i[BIT_WIDTH-1] ? -dividend_i : dividend_i;
    st_d[0].dvs  = divisor_i[BIT_WIDTH-1] ? -divisor_i : divisor_i;
`else
    st_d[0].dq   = dividend_i;
    st_d[0].dvs  = divisor_i;
`endif
    for (int i = 1; i < STAGES; i++) begin
      st_d[i] = step(st_q[i-1]);
    end
  end

  // Last iteration group and output fix-up feed the result register
  always_comb begin
    res    = fixup(step(st_q[STAGES-1]));
    done_d = st_q[STAGES-1].vld;
    quot_d = quot_q;
    rem_d  = rem_q;
    dz_d   = dz_q;
    if (st_q[STAGES-1].vld) begin
      quot_d = res.q;
      rem_d  = res.r;
      dz_d   = st_q[STAGES-1].dz;
    end
  end

  // Stage data loads only behind a valid op; bubbles just clear valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) st_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (st_d[i].vld) st_q[i] <= st_d[i];
        else             st_q[i].vld <= 1'b0;
      end
    end
  end

  // Result register holds between done pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_pipe_div.sv
// Scoreboard bench for pipe_div: directed corners, mid-op reset,
// and a back-to-back random soak against a reference model.
module tb_pipe_div;

  localparam int W = 32;
  localparam int S = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         start;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         done;

  pipe_div #(.BIT_WIDTH(W), .STAGES(S)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .start_i     (start),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .div_zero_o  (div_zero),
    .done_o      (done)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   cyc    = 0;
  int   n_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        check("latency", cyc, e.cyc);
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    e.cyc = 0;
    e.dz  = 1'b0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
`ifdef PIPE_DIV_SIGNED_EN
      logic signed [W-1:0] sa, sd;
      sa = a;
      sd = b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = a;
        e.r = '0;
      end else begin
        e.q = sa / sd;
        e.r = sa % sd;
      end
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.dz  = ez;
    e.cyc = cyc + 1 + S;
    sb.push_back(e);
  endtask

  task automatic issue_m(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(a, b);
    issue(a, b, e.q, e.r, e.dz);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (sb.size() != 0 && t < 4 * S) begin
      @(negedge clk);
      start = 1'b0;
      t++;
    end
    check("drain_timeout", sb.size(), 32'd0);
  endtask

  function automatic logic [W-1:0] rnd_op;
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return $urandom_range(1, 15);
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom & 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    // Single op latency, nothing else in flight
    issue(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    idle(S + 4);
    check("basic_count", n_done, 32'd1);
    check("hold_after", quotient, 32'd3);

    // Corners
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef PIPE_DIV_SIGNED_EN
    issue(32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd0, 1'b0);
`else
    issue(32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0);
`endif
    issue(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1);
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    idle(2);

    // Back-to-back then hold
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    issue(32'd81, 32'd9, 32'd9, 32'd0, 1'b0);
    drain();
    idle(5);
    check("hold_q", quotient, 32'd9);
    check("hold_r", remainder, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);

`ifdef PIPE_DIV_SIGNED_EN
    issue(-32'sd20, 32'd3, -32'sd6, -32'sd2, 1'b0);
    issue(32'd20, -32'sd3, -32'sd6, 32'd2, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    issue(-32'sd7, 32'd0, 32'hFFFF_FFFF, -32'sd7, 1'b1);
    drain();
`endif

    // Reset with an op in flight; start held high through reset
    issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
    idle(8);
    d0 = n_done;
    @(negedge clk);
    dividend = 32'd77;
    divisor  = 32'd7;
    start    = 1'b1;
    rst_n    = 1'b0;
    sb.delete();
    #1;
    check("midrst_quot", quotient, 32'd0);
    check("midrst_rem", remainder, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    idle(2 * S);
    check("midrst_no_done", n_done - d0, 32'd0);
    check("midrst_hold", quotient, 32'd0);

    // Soak: one random op every cycle
    for (int i = 0; i < 10000; i++) begin
      issue_m(rnd_op(), rnd_op());
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
